// File: rtl/kws_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kws_pkg
//  Purpose  : Shared types and constants for the KWS accelerator PSRAM path.
//             Holds the arbiter state type, the PSRAM data width and the
//             requester index map used to pack requester ports at top level.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package kws_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int PSRAM_DW = 4;

    // Requester slot assignment on the arbiter's packed request ports.
    localparam int REQ_CONV1   = 0;
    localparam int REQ_CONV2   = 1;
    localparam int REQ_FC1     = 2;
    localparam int REQ_FC2     = 3;
    localparam int REQ_MAXPOOL = 4;
    localparam int REQ_SOFTMAX = 5;
    localparam int REQ_HOST    = 6;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational rotate-priority encoder. Returns the first set
//             request bit at or after ptr, wrapping around to bit 0.
//  Ports    : req   - request vector
//             ptr   - highest-priority position (must be < NUM_REQ)
//             valid - at least one request is set
//             idx   - selected requester index
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 7,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Two lowest-index searches: one over bits >= ptr (preferred), one over
    // bits < ptr (the wrapped part). The wrapped winner is used only when
    // nothing at or above ptr is requesting.
    logic             found_hi;
    logic             found_lo;
    logic [IDX_W-1:0] idx_hi;
    logic [IDX_W-1:0] idx_lo;

    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                if (IDX_W'(i) >= ptr) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        idx_hi   = IDX_W'(i);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    idx_lo   = IDX_W'(i);
                end
            end
        end
        valid = found_hi | found_lo;
        idx   = found_hi ? idx_hi : idx_lo;
    end

endmodule
`default_nettype wire

// File: rtl/psram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : psram_arbiter
//  Purpose  : Round-robin request/grant arbiter sharing one quad-SPI PSRAM
//             between the layer engines and the host loader. Grants are held
//             for whole transactions (until req drops and CE# is high), a
//             turnaround gap with CE# high separates owners, and a watchdog
//             preempts grants longer than MAX_HOLD cycles.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req                 - per-requester level request
//             gnt, gnt_idx        - registered one-hot grant / owner index
//             busy                - arbiter in GRANT or TURN
//             timeout_err         - one-cycle pulse after watchdog preemption
//             req_sck/ce_n/dout/douten - per-requester PSRAM pins
//             psram_din, req_din  - PSRAM read data and its broadcast copy
//             psram_sck/ce_n/dout/douten - shared PSRAM pins
//  Revision : 1.0 - initial release
// ============================================================================
module psram_arbiter
    import kws_pkg::*;
#(
    parameter int NUM_REQ    = 7,
    parameter int IDX_W      = 3,
    parameter int TURNAROUND = 2,
    parameter int MAX_HOLD   = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [IDX_W-1:0]             gnt_idx,
    output logic                         busy,
    output logic                         timeout_err,
    input  logic [NUM_REQ-1:0]           req_sck,
    input  logic [NUM_REQ-1:0]           req_ce_n,
    input  logic [PSRAM_DW*NUM_REQ-1:0]  req_dout,
    input  logic [PSRAM_DW*NUM_REQ-1:0]  req_douten,
    input  logic [PSRAM_DW-1:0]          psram_din,
    output logic [PSRAM_DW-1:0]          req_din,
    output logic                         psram_sck,
    output logic                         psram_ce_n,
    output logic [PSRAM_DW-1:0]          psram_dout,
    output logic [PSRAM_DW-1:0]          psram_douten
);

    localparam int                 HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam int                 TURN_W    = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [TURN_W-1:0]  TURN_LOAD = TURN_W'(TURNAROUND - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TURN_W-1:0] turn_cnt;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic              do_grant;
    logic              do_release;
    logic              do_timeout;
    logic              in_grant;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and transition strobes. A normal release always wins over
    // the watchdog when both happen in the same cycle.
    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_release = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    do_grant  = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[gnt_idx] && req_ce_n[gnt_idx]) begin
                    do_release = 1'b1;
                    state_nxt  = TURN;
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
                    do_timeout = 1'b1;
                    state_nxt  = TURN;
                end
            end
            TURN: begin
                if (turn_cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
            turn_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= do_timeout;

            if (do_grant) begin
                gnt      <= NUM_REQ'(1) << pick_idx;
                gnt_idx  <= pick_idx;
                ptr      <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                hold_cnt <= '0;
            end else if (state == GRANT) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            if (do_release || do_timeout) begin
                gnt      <= '0;
                turn_cnt <= TURN_LOAD;
            end else if (state == TURN) begin
                turn_cnt <= turn_cnt - 1'b1;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign in_grant = (state == GRANT);

    // Pin mux is steered by the registered owner index; outside GRANT the
    // bus is parked with CE# deasserted and all drivers off.
    assign psram_ce_n   = in_grant ? req_ce_n[gnt_idx] : 1'b1;
    assign psram_sck    = in_grant ? req_sck[gnt_idx]  : 1'b0;
    assign psram_dout   = in_grant ? req_dout[gnt_idx*PSRAM_DW +: PSRAM_DW]   : '0;
    assign psram_douten = in_grant ? req_douten[gnt_idx*PSRAM_DW +: PSRAM_DW] : '0;
    assign req_din      = psram_din;

endmodule
`default_nettype wire

// File: tb/tb_psram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psram_arbiter
//  Purpose  : Self-checking bench for psram_arbiter (NUM_REQ=7, TURNAROUND=2,
//             MAX_HOLD=16). A cycle-level reference model written in terms of
//             owner / cycles-held / cycles-since-release runs alongside the
//             directed sequences and a randomized phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_psram_arbiter;

    localparam int N  = 7;
    localparam int IW = 3;
    localparam int TA = 2;
    localparam int MH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_sck = '0;
    logic [N-1:0]    req_ce_n = '1;
    logic [4*N-1:0]  req_dout = '0;
    logic [4*N-1:0]  req_douten = '0;
    logic [3:0]      psram_din = '0;

    logic [N-1:0]    gnt;
    logic [IW-1:0]   gnt_idx;
    logic            busy;
    logic            timeout_err;
    logic [3:0]      req_din;
    logic            psram_sck;
    logic            psram_ce_n;
    logic [3:0]      psram_dout;
    logic [3:0]      psram_douten;

    psram_arbiter #(
        .NUM_REQ    (N),
        .IDX_W      (IW),
        .TURNAROUND (TA),
        .MAX_HOLD   (MH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .gnt          (gnt),
        .gnt_idx      (gnt_idx),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .req_sck      (req_sck),
        .req_ce_n     (req_ce_n),
        .req_dout     (req_dout),
        .req_douten   (req_douten),
        .psram_din    (psram_din),
        .req_din      (req_din),
        .psram_sck    (psram_sck),
        .psram_ce_n   (psram_ce_n),
        .psram_dout   (psram_dout),
        .psram_douten (psram_douten)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the bus, how long they have held it, and how
    // many non-owned cycles have elapsed since the last owner let go.
    int m_owner = -1;
    int m_last  = 0;
    int m_age   = 0;
    int m_free  = 100;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        bit found;
        int g;
        if (rst) begin
            m_owner = -1;
            m_last  = 0;
            m_age   = 0;
            m_free  = 100;
            m_ptr   = 0;
            m_to    = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!req[m_owner] && req_ce_n[m_owner]) begin
                m_owner = -1;
                m_free  = 1;
            end else if (m_age == MH) begin
                m_owner = -1;
                m_free  = 1;
                m_to    = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_free >= TA + 1 && req != '0) begin
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    g     = (m_ptr + k) % N;
                end
            end
            m_owner = g;
            m_last  = g;
            m_age   = 1;
            m_ptr   = (g + 1) % N;
        end else if (m_free < 100) begin
            m_free++;
        end
    endtask

    function automatic logic [9:0] exp_pins();
        if (m_owner >= 0)
            return {req_ce_n[m_owner], req_sck[m_owner],
                    req_dout[4*m_owner +: 4], req_douten[4*m_owner +: 4]};
        return {1'b1, 1'b0, 8'h00};
    endfunction

    task automatic check_pins();
        chk("pins", 32'({psram_ce_n, psram_sck, psram_dout, psram_douten}), 32'(exp_pins()));
        chk("req_din", 32'(req_din), 32'(psram_din));
    endtask

    task automatic check_regs();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_idx", 32'(gnt_idx), 32'(m_last));
        chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_free <= TA)));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
        check_pins();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req        = '0;
        req_ce_n   = '1;
        req_sck    = '0;
        req_dout   = '0;
        req_douten = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  gnt;
        logic [IW-1:0] idx;
        logic          busy;
    } vec_t;

    vec_t vecs[6];
    int   exp_order[4];

    initial begin
        int gap;
        int cnt;

        // First grant out of reset (ptr = 0): lowest set bit wins.
        vecs[0] = '{req: 7'h7F,       gnt: 7'h01, idx: 3'd0, busy: 1'b1};
        vecs[1] = '{req: 7'b0010110,  gnt: 7'h02, idx: 3'd1, busy: 1'b1};
        vecs[2] = '{req: 7'h40,       gnt: 7'h40, idx: 3'd6, busy: 1'b1};
        vecs[3] = '{req: 7'h30,       gnt: 7'h10, idx: 3'd4, busy: 1'b1};
        vecs[4] = '{req: 7'h00,       gnt: 7'h00, idx: 3'd0, busy: 1'b0};
        vecs[5] = '{req: 7'h08,       gnt: 7'h08, idx: 3'd3, busy: 1'b1};
        exp_order = '{1, 2, 4, 1};

        @(posedge clk);
        #1;

        // 1: reset held with all requests up
        rst = 1'b1;
        req = 7'h7F;
        repeat (3) begin
            tick();
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_ce_n", 32'(psram_ce_n), 32'h1);
        end
        rst = 1'b0;
        tick();
        chk("first_gnt", 32'(gnt), 32'h01);
        chk("first_idx", 32'(gnt_idx), 32'h0);

        // Table: first grant after reset for several request patterns
        for (int v = 0; v < 6; v++) begin
            do_reset();
            req = vecs[v].req;
            tick();
            chk("tbl_gnt", 32'(gnt), 32'(vecs[v].gnt));
            chk("tbl_idx", 32'(gnt_idx), 32'(vecs[v].idx));
            chk("tbl_busy", 32'(busy), 32'(vecs[v].busy));
        end

        // 2: round-robin order with measured gaps
        do_reset();
        req = 7'b0010110;
        tick();
        gap = 0;
        for (int n = 0; n < 4; n++) begin
            chk("rr_gnt", 32'(gnt), 32'(N'(1) << exp_order[n]));
            if (n > 0) chk("rr_gap", 32'(gap), 32'(TA + 1));
            req_ce_n[exp_order[n]] = 1'b0;
            repeat (5) tick();
            req_ce_n[exp_order[n]] = 1'b1;
            req[exp_order[n]]      = 1'b0;
            tick();
            req[exp_order[n]] = 1'b1;
            gap = 0;
            while (gnt == '0 && gap < 20) begin
                gap++;
                tick();
            end
        end

        // 3: late CE# release holds the grant
        do_reset();
        req[3] = 1'b1;
        tick();
        chk("late_gnt", 32'(gnt), 32'h08);
        req_ce_n[3] = 1'b0;
        tick();
        req[3] = 1'b0;
        repeat (4) begin
            tick();
            chk("late_hold", 32'(gnt[3]), 32'h1);
        end
        req_ce_n[3] = 1'b1;
        tick();
        chk("late_drop", 32'(gnt), 32'h0);
        chk("late_ce_n", 32'(psram_ce_n), 32'h1);

        // 4: watchdog preempts requester 5, then requester 0 is served
        do_reset();
        req[5] = 1'b1;
        req_ce_n[5] = 1'b0;
        tick();
        req[0] = 1'b1;
        cnt = 0;
        while (gnt[5] && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("wd_len", 32'(cnt), 32'(MH));
        chk("wd_pulse", 32'(timeout_err), 32'h1);
        tick();
        chk("wd_pulse_end", 32'(timeout_err), 32'h0);
        gap = 0;
        while (gnt == '0 && gap < 20) begin
            gap++;
            tick();
        end
        chk("wd_next", 32'(gnt), 32'h01);

        // 6: reset in the middle of a grant
        do_reset();
        req[2] = 1'b1;
        tick();
        req_ce_n[2] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_ce_n", 32'(psram_ce_n), 32'h1);
        rst      = 1'b0;
        req      = 7'h7F;
        req_ce_n = '1;
        tick();
        chk("mid_rst_ptr", 32'(gnt), 32'h01);

        // 5: randomized traffic with non-owner pin noise
        do_reset();
        for (int c = 0; c < 900; c++) begin
            req        = req ^ N'($urandom & $urandom & $urandom);
            req_ce_n   = N'($urandom | $urandom);
            req_sck    = N'($urandom);
            req_dout   = 28'($urandom);
            req_douten = 28'($urandom);
            psram_din  = 4'($urandom);
            #1;
            check_pins();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
